icache: RTL and testbench

- Direct-mapped, read-only instruction cache with one-word blocks.
- Sits between the pipeline fetch stage and memory_control, directly upstream of the arbiter.
- Serves fetches on hit in zero added cycles.
- On miss, drives iREN/iaddr into memory_control, holds until iwait falls, then fills the entry.

---
 rtl/icache.sv | 85 ++++++++
 tb/tb_icache.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with one-word blocks.
// Hits are served combinationally; misses hold iREN until memory_control drops iwait.
module icache #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              iflush,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] miss_addr_q, miss_addr_d;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [WORD_W-1:0] data_q [SETS];
    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag, fill_tag;
    logic              fill_done;
    logic              unused_ofs;

    assign idx        = imemaddr[IDX_W+1:2];
    assign tag        = imemaddr[WORD_W-1:IDX_W+2];
    assign fill_idx   = miss_addr_q[IDX_W+1:2];
    assign fill_tag   = miss_addr_q[WORD_W-1:IDX_W+2];
    assign unused_ofs = ^imemaddr[1:0];

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;
        fill_done   = 1'b0;
        if (state_q == IDLE) begin
            ihit     = imemREN & valid_q[idx] & (tag_q[idx] == tag) & ~iflush;
            imemload = ihit ? data_q[idx] : '0;
            if (imemREN & ~ihit) begin
                miss_addr_d = {imemaddr[WORD_W-1:2], 2'b00};
                state_d     = FILL;
            end
        end else begin
            iREN      = 1'b1;
            iaddr     = miss_addr_q;
            fill_done = ~iwait;
            state_d   = iwait ? FILL : IDLE;
        end
    end

    // Flush is applied before the fill write so a coinciding fill keeps its entry valid.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (iflush)
                valid_q <= '0;
            if (fill_done)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench; stimulus queues expected fills and hit data,
// a negedge monitor pops and compares whenever the cache requests memory or hits.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST, imemREN, iflush, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fill [$];
    logic [31:0] exp_hit  [$];
    logic [31:0] cur_fill = '0;
    logic        iren_prev = 1'b0;

    icache #(.SETS(16), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a rising iREN is a new fill request; ihit presents a word to the fetch stage.
    always @(negedge CLK) begin
        if (iREN && !iren_prev) begin
            if (exp_fill.size() == 0) begin
                chk("unexpected_fill", iaddr, 32'hFFFF_FFFF);
            end else begin
                cur_fill = exp_fill.pop_front();
                chk("fill_addr", iaddr, cur_fill);
            end
        end else if (iREN) begin
            chk("fill_addr_hold", iaddr, cur_fill);
        end
        if (ihit) begin
            if (exp_hit.size() == 0)
                chk("unexpected_hit", imemload, 32'hFFFF_FFFF);
            else
                chk("hit_data", imemload, exp_hit.pop_front());
        end else if (imemload !== 32'h0) begin
            chk("load_zero_on_miss", imemload, 32'h0);
        end
        iren_prev = iREN;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d);
        imemREN  = 1'b1;
        imemaddr = a;
        exp_hit.push_back(d);
        tick();
    endtask

    // Miss with n wait cycles; fd/fc raise iflush in the detect/completion cycle.
    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int n,
                        input logic fd, input logic fc);
        imemREN  = 1'b1;
        imemaddr = a;
        iflush   = fd;
        exp_fill.push_back({a[31:2], 2'b00});
        exp_hit.push_back(d);
        #1 chk("miss_no_hit", {31'b0, ihit}, 32'd0);
        tick();
        iflush = 1'b0;
        repeat (n) tick();
        iwait  = 1'b0;
        iload  = d;
        iflush = fc;
        tick();
        iwait  = 1'b1;
        iload  = '0;
        iflush = 1'b0;
        tick();
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b1; iload = '0;
        tick(); tick();
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_iren", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        nRST = 1'b1;
        tick();

        fill(32'h0000_0000, 32'h3C01_0001, 2, 1'b0, 1'b0);
        hit(32'h0000_0000, 32'h3C01_0001);
        hit(32'h0000_0002, 32'h3C01_0001);

        fill(32'h0000_0004, 32'hAAAA_0001, 1, 1'b0, 1'b0);
        fill(32'h0000_0044, 32'hBBBB_0002, 3, 1'b0, 1'b0);
        fill(32'h0000_0004, 32'hAAAA_0001, 0, 1'b0, 1'b0);

        // Redirect: the fill keeps its latched address, then the new address misses.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        exp_fill.push_back(32'h0000_0010);
        tick();
        imemaddr = 32'h0000_0020;
        tick(); tick();
        iwait = 1'b0; iload = 32'h1111_0010;
        exp_fill.push_back(32'h0000_0020);
        exp_hit.push_back(32'h2222_0020);
        tick();
        iwait = 1'b1; iload = '0;
        chk("redirect_miss", {31'b0, ihit}, 32'd0);
        tick();
        tick();
        iwait = 1'b0; iload = 32'h2222_0020;
        tick();
        iwait = 1'b1; iload = '0;
        tick();
        hit(32'h0000_0010, 32'h1111_0010);

        fill(32'h0000_0008, 32'h0808_0808, 1, 1'b0, 1'b0);
        fill(32'h0000_000C, 32'h0C0C_0C0C, 1, 1'b0, 1'b0);
        hit(32'h0000_0000, 32'h3C01_0001);
        hit(32'h0000_0004, 32'hAAAA_0001);
        hit(32'h0000_0008, 32'h0808_0808);
        hit(32'h0000_000C, 32'h0C0C_0C0C);
        fill(32'h0000_0004, 32'h4444_0004, 1, 1'b1, 1'b0);
        fill(32'h0000_0000, 32'h3C01_0001, 1, 1'b0, 1'b0);

        fill(32'h0000_0008, 32'h8888_0008, 2, 1'b0, 1'b1);
        hit(32'h0000_0008, 32'h8888_0008);
        fill(32'h0000_0000, 32'h3C01_0001, 1, 1'b0, 1'b0);
        fill(32'h0000_0004, 32'h4444_0004, 1, 1'b0, 1'b0);

        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        exp_fill.push_back(32'h0000_0010);
        tick(); tick();
        nRST = 1'b0; imemREN = 1'b0;
        tick();
        chk("midrst_iren", {31'b0, iREN}, 32'd0);
        chk("midrst_iaddr", iaddr, 32'h0);
        chk("midrst_ihit", {31'b0, ihit}, 32'd0);
        nRST = 1'b1;
        tick();
        fill(32'h0000_0010, 32'h1010_1010, 1, 1'b0, 1'b0);
        hit(32'h0000_0010, 32'h1010_1010);

        imemREN = 1'b0;
        tick(); tick();
        chk("fill_queue_empty", exp_fill.size(), 32'd0);
        chk("hit_queue_empty", exp_hit.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
